// File: rtl/reg_dump_reader.sv
// Register-file read-back engine: walks registers FIRST..LAST through one read
// port and streams each word with its index over valid/ready, freezing writes meanwhile.
module reg_dump_reader #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32,
   parameter int FIRST  = 0,
   parameter int LAST   = 31
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   output logic [ADDR_W-1:0] rf_addr,
   input  logic [DATA_W-1:0] rf_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [ADDR_W-1:0] out_index,
   output logic              busy,
   output logic              freeze,
   output logic              done
);

   localparam logic [ADDR_W-1:0] FIRST_A = ADDR_W'(FIRST);
   localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST);

   typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] addr, addr_nxt;
   logic              valid_nxt;
   logic              capture;
   logic              hs;

   assign hs = out_valid & out_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      addr_nxt  = addr;
      valid_nxt = out_valid;
      capture   = 1'b0;
      case (state)
         IDLE: begin
            if (start && !abort) begin
               state_nxt = READ;
               addr_nxt  = FIRST_A;
            end
         end
         READ: begin
            state_nxt = SEND;
            valid_nxt = 1'b1;
            capture   = 1'b1;
         end
         SEND: begin
            if (hs) begin
               valid_nxt = 1'b0;
               if (addr == LAST_A) begin
                  state_nxt = DONE;
               end else begin
                  state_nxt = READ;
                  addr_nxt  = addr + ADDR_W'(1);
               end
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      // abort beats everything, including a handshake landing on the same edge
      if (abort && state != IDLE) begin
         state_nxt = IDLE;
         valid_nxt = 1'b0;
         capture   = 1'b0;
         addr_nxt  = addr;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr      <= FIRST_A;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_index <= '0;
      end else begin
         addr      <= addr_nxt;
         out_valid <= valid_nxt;
         if (capture) begin
            out_data  <= rf_data;
            out_index <= addr;
         end
      end
   end

   assign rf_addr = addr;
   assign busy    = (state != IDLE);
   assign freeze  = busy;
   assign done    = (state == DONE);

endmodule

// File: tb/tb_reg_dump_reader.sv
// Scoreboard bench for reg_dump_reader: full range instance (0..31) and a
// single-register instance (5..5).
module tb_reg_dump_reader;

   typedef struct packed {
      logic [4:0]  idx;
      logic [31:0] data;
   } word_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        start, abort, out_ready;
   logic [4:0]  rf_addr, out_index;
   logic [31:0] rf_data, out_data;
   logic        out_valid, busy, freeze, done;

   logic        start2, abort2, out_ready2;
   logic [4:0]  rf_addr2, out_index2;
   logic [31:0] rf_data2, out_data2;
   logic        out_valid2, busy2, freeze2, done2;

   logic [31:0] rf_a [32];
   logic [31:0] rf_b [32];

   word_t sb[$];
   word_t exp_w;
   int    checks = 0;
   int    failures = 0;

   always #5 clk = ~clk;

   assign rf_data  = rf_a[rf_addr];
   assign rf_data2 = rf_b[rf_addr2];

   reg_dump_reader #(.ADDR_W(5), .DATA_W(32), .FIRST(0), .LAST(31)) u_dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .rf_addr(rf_addr), .rf_data(rf_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_index(out_index),
      .busy(busy), .freeze(freeze), .done(done));

   reg_dump_reader #(.ADDR_W(5), .DATA_W(32), .FIRST(5), .LAST(5)) u_one (
      .clk(clk), .reset(reset), .start(start2), .abort(abort2),
      .rf_addr(rf_addr2), .rf_data(rf_data2), .out_valid(out_valid2),
      .out_ready(out_ready2), .out_data(out_data2), .out_index(out_index2),
      .busy(busy2), .freeze(freeze2), .done(done2));

   task automatic test_reset;
      reset = 1'b0;
      #12;
      checks++;
      if ({out_valid, busy, freeze, done} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_ctrl: got %b expected 0000", {out_valid, busy, freeze, done});
      end
      checks++;
      if (out_data !== 32'h0 || out_index !== 5'd0 || rf_addr !== 5'd0) begin
         failures++;
         $display("FAIL reset_data: got data=%h idx=%0d rf_addr=%0d expected 0/0/0", out_data, out_index, rf_addr);
      end
      checks++;
      if (rf_addr2 !== 5'd5 || busy2 !== 1'b0) begin
         failures++;
         $display("FAIL reset_one: got rf_addr=%0d busy=%b expected 5/0", rf_addr2, busy2);
      end
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_full_dump;
      int edges, last_acc, done_at;
      sb.delete();
      for (int i = 0; i < 32; i++) sb.push_back('{idx: 5'(i), data: rf_a[i]});
      @(negedge clk);
      out_ready = 1'b1;
      start = 1'b1;
      edges = 0; last_acc = -1; done_at = -1;
      while (edges < 200 && done_at < 0) begin
         @(posedge clk); edges++;
         @(negedge clk); start = 1'b0;
         checks++;
         if (freeze !== busy || busy !== 1'b1) begin
            failures++;
            $display("FAIL full_freeze: got busy=%b freeze=%b expected 1/1 at edge %0d", busy, freeze, edges);
         end
         if (out_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL full_extra_word: got idx=%0d expected none", out_index);
            end else begin
               exp_w = sb.pop_front();
               if (out_index !== exp_w.idx || out_data !== exp_w.data) begin
                  failures++;
                  $display("FAIL full_word: got %0d/%h expected %0d/%h", out_index, out_data, exp_w.idx, exp_w.data);
               end
            end
            if (last_acc >= 0) begin
               checks++;
               if (edges - last_acc != 2) begin
                  failures++;
                  $display("FAIL full_spacing: got %0d cycles expected 2", edges - last_acc);
               end
            end
            last_acc = edges;
         end
         if (done === 1'b1) done_at = edges;
      end
      checks++;
      if (done_at != 65) begin
         failures++;
         $display("FAIL full_done_cycle: got %0d expected 65", done_at);
      end
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL full_missing: got %0d words left expected 0", sb.size());
      end
      @(posedge clk); @(negedge clk);
      checks++;
      if ({busy, freeze, done, out_valid} !== 4'b0000) begin
         failures++;
         $display("FAIL full_after: got %b expected 0000", {busy, freeze, done, out_valid});
      end
   endtask

   task automatic test_backpressure;
      int edges, done_at, n_done;
      logic hold;
      logic [31:0] hold_data;
      logic [4:0]  hold_idx;
      sb.delete();
      for (int i = 0; i < 32; i++) sb.push_back('{idx: 5'(i), data: rf_a[i]});
      @(negedge clk);
      start = 1'b1;
      out_ready = 1'b0;
      edges = 0; done_at = -1; n_done = 0; hold = 1'b0;
      hold_data = '0; hold_idx = '0;
      while (edges < 2000 && done_at < 0) begin
         @(posedge clk); edges++;
         @(negedge clk); start = 1'b0;
         checks++;
         if (freeze !== 1'b1) begin
            failures++;
            $display("FAIL bp_freeze: got %b expected 1 at edge %0d", freeze, edges);
         end
         if (hold) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== hold_data || out_index !== hold_idx) begin
               failures++;
               $display("FAIL bp_stable: got v=%b %0d/%h expected 1 %0d/%h", out_valid, out_index, out_data, hold_idx, hold_data);
            end
         end
         out_ready = ($urandom_range(0, 1) == 1);
         hold = 1'b0;
         if (out_valid === 1'b1) begin
            if (out_ready) begin
               checks++;
               if (sb.size() == 0) begin
                  failures++;
                  $display("FAIL bp_extra_word: got idx=%0d expected none", out_index);
               end else begin
                  exp_w = sb.pop_front();
                  if (out_index !== exp_w.idx || out_data !== exp_w.data) begin
                     failures++;
                     $display("FAIL bp_word: got %0d/%h expected %0d/%h", out_index, out_data, exp_w.idx, exp_w.data);
                  end
               end
            end else begin
               hold = 1'b1; hold_data = out_data; hold_idx = out_index;
            end
         end
         if (done === 1'b1) begin done_at = edges; n_done++; end
      end
      checks++;
      if (done_at < 0 || sb.size() != 0) begin
         failures++;
         $display("FAIL bp_complete: got done_at=%0d left=%0d expected done and 0 left", done_at, sb.size());
      end
      out_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL bp_after: got busy=%b done=%b expected 0/0", busy, done);
      end
   endtask

   task automatic test_abort;
      int edges;
      logic seen;
      @(negedge clk);
      out_ready = 1'b1;
      start = 1'b1;
      edges = 0; seen = 1'b0;
      while (edges < 100 && !seen) begin
         @(posedge clk); edges++;
         @(negedge clk); start = 1'b0;
         if (out_valid === 1'b1 && out_index === 5'd7) begin
            seen = 1'b1;
            out_ready = 1'b0;
            abort = 1'b1;
         end
      end
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL abort_reach7: got timeout expected index 7 in SEND");
      end
      @(posedge clk); @(negedge clk);
      abort = 1'b0;
      checks++;
      if ({busy, out_valid, done} !== 3'b000) begin
         failures++;
         $display("FAIL abort_idle: got busy/valid/done=%b expected 000", {busy, out_valid, done});
      end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); @(negedge clk);
         checks++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_no_done: got done=%b busy=%b expected 0/0", done, busy);
         end
      end
      out_ready = 1'b1;
      start = 1'b1;
      edges = 0; seen = 1'b0;
      while (edges < 10 && !seen) begin
         @(posedge clk); edges++;
         @(negedge clk); start = 1'b0;
         if (out_valid === 1'b1) seen = 1'b1;
      end
      checks++;
      if (!seen || out_index !== 5'd0 || out_data !== rf_a[0] || edges != 2) begin
         failures++;
         $display("FAIL abort_restart: got seen=%b idx=%0d data=%h edge=%0d expected 1/0/%h/2", seen, out_index, out_data, edges, rf_a[0]);
      end
      abort = 1'b1;
      @(posedge clk); @(negedge clk);
      abort = 1'b0;
   endtask

   task automatic test_reset_mid;
      int edges;
      logic seen;
      @(negedge clk);
      out_ready = 1'b1;
      start = 1'b1;
      edges = 0; seen = 1'b0;
      while (edges < 100 && !seen) begin
         @(posedge clk); edges++;
         @(negedge clk); start = 1'b0;
         if (out_valid === 1'b1 && out_index === 5'd12) begin
            seen = 1'b1;
            out_ready = 1'b0;
         end
      end
      @(posedge clk); @(negedge clk);
      checks++;
      if (!seen || out_valid !== 1'b1 || out_index !== 5'd12) begin
         failures++;
         $display("FAIL rst_mid_wait: got v=%b idx=%0d expected 1/12", out_valid, out_index);
      end
      reset = 1'b0;
      #1;
      checks++;
      if ({out_valid, busy, freeze, done} !== 4'b0000 || out_data !== 32'h0 ||
          out_index !== 5'd0 || rf_addr !== 5'd0) begin
         failures++;
         $display("FAIL rst_mid_async: got v/b/f/d=%b data=%h idx=%0d rf_addr=%0d expected 0000/0/0/0",
                  {out_valid, busy, freeze, done}, out_data, out_index, rf_addr);
      end
      @(negedge clk);
      reset = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      checks++;
      if (busy !== 1'b0 || rf_addr !== 5'd0 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid_release: got busy=%b rf_addr=%0d v=%b expected 0/0/0", busy, rf_addr, out_valid);
      end
   endtask

   task automatic test_start_abort_idle;
      @(negedge clk);
      start = 1'b1;
      abort = 1'b1;
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (busy !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL start_abort_idle: got busy=%b v=%b expected 0/0", busy, out_valid);
         end
         @(posedge clk); @(negedge clk);
      end
   endtask

   task automatic test_single;
      int edges, done_at, words;
      sb.delete();
      sb.push_back('{idx: 5'd5, data: 32'hDEADBEEF});
      @(negedge clk);
      out_ready2 = 1'b1;
      start2 = 1'b1;
      edges = 0; done_at = -1; words = 0;
      while (edges < 20 && done_at < 0) begin
         @(posedge clk); edges++;
         @(negedge clk);
         start2 = (edges == 1);
         if (out_valid2 === 1'b1) begin
            words++;
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL single_extra_word: got idx=%0d expected none", out_index2);
            end else begin
               exp_w = sb.pop_front();
               if (out_index2 !== exp_w.idx || out_data2 !== exp_w.data) begin
                  failures++;
                  $display("FAIL single_word: got %0d/%h expected %0d/%h", out_index2, out_data2, exp_w.idx, exp_w.data);
               end
            end
         end
         if (done2 === 1'b1) done_at = edges;
      end
      start2 = 1'b0;
      checks++;
      if (done_at != 3 || words != 1) begin
         failures++;
         $display("FAIL single_done: got done_at=%0d words=%0d expected 3/1", done_at, words);
      end
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); @(negedge clk);
         checks++;
         if (busy2 !== 1'b0 || out_valid2 !== 1'b0 || done2 !== 1'b0) begin
            failures++;
            $display("FAIL single_start_ignored: got busy=%b v=%b done=%b expected 000", busy2, out_valid2, done2);
         end
      end
   endtask

   initial begin
      start = 1'b0; abort = 1'b0; out_ready = 1'b0;
      start2 = 1'b0; abort2 = 1'b0; out_ready2 = 1'b0;
      for (int i = 0; i < 32; i++) begin
         rf_a[i] = 32'hA5A50000 + 32'(i);
         rf_b[i] = $urandom;
      end
      rf_b[5] = 32'hDEADBEEF;
      test_reset();
      test_full_dump();
      test_backpressure();
      test_abort();
      test_reset_mid();
      test_start_abort_idle();
      test_single();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
